// File: rtl/restador_seq_ctrl.sv
// restador_seq_ctrl: computes A - B one nibble per clock through a single 4-bit subtractor slice.
// Latency: N+1 cycles from accepted start to the done pulse (N = WIDTH/4).
// Backpressure: none; start is only sampled in IDLE or DONE and is ignored while busy.
// Optional feature macro: RESTADOR_SIGNED_EN (enables the registered signed-overflow flag).
module restador_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             cout_co,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  // Slice datapath: select the current nibble of each latched operand.
  logic [CW+1:0]    sh;
  logic [WIDTH-1:0] a_sh, b_sh, diff_upd;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       sum5;

  // One subtractor slice: {c, s} = a_nib + ~b_nib + carry, merged into diff at the nibble slot.
  always_comb begin
    sh       = {cnt_q, 2'b00};
    a_sh     = a_q >> sh;
    b_sh     = b_q >> sh;
    a_nib    = a_sh[3:0];
    b_nib    = b_sh[3:0];
    sum5     = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'd0, carry_q};
    diff_upd = (diff_q & ~(NIB_MASK << sh)) | (WIDTH'(sum5[3:0]) << sh);
  end

  // Next-state and datapath register updates; everything holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        diff_d  = diff_upd;
        carry_d = sum5[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          cout_d  = sum5[4];
          zero_d  = (diff_upd == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

`ifdef RESTADOR_SIGNED_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands of opposite sign and the result sign differs from the minuend.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == CALC && cnt_q == LAST) begin
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_upd[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  // Overflow flag register, updated together with the other flags on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign diff    = diff_q;
  assign cout_co = cout_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_restador_seq_ctrl.sv
// Directed bench for restador_seq_ctrl at WIDTH=16 and WIDTH=4.
// Table of operand/expected-result records plus hand-written multi-cycle sequences.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_restador_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start4;
  logic [15:0] a16, b16;
  logic [3:0]  a4, b4;
  logic        busy16, done16, cout16, zero16, ovf16;
  logic [15:0] diff16;
  logic        busy4, done4, cout4, zero4, ovf4;
  logic [3:0]  diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  restador_seq_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .cout_co(cout16), .zero(zero16), .ovf(ovf16)
  );

  restador_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .cout_co(cout4), .zero(zero4), .ovf(ovf4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        cout;
    logic        zero;
    logic        ovf_signed;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns just after the accepting edge.
  task automatic start_op16(input logic [15:0] av, input logic [15:0] bv);
    a16 = av;
    b16 = bv;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  // Count edges until done appears (bounded), and cycles with busy high including the current one.
  task automatic wait_done16(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = busy16 ? 1 : 0;
    while (!done16 && cyc < 40) begin
      tick();
      cyc++;
      if (!done16 && busy16) busy_cnt++;
    end
  endtask

  task automatic do_op(input vec_t v, input string nm);
    int cyc, bc;
    logic exp_ovf;
`ifdef RESTADOR_SIGNED_EN
    exp_ovf = v.ovf_signed;
`else
    exp_ovf = 1'b0;
`endif
    start_op16(v.a, v.b);
    // Operands may change after acceptance; only the latched copies count.
    a16 = ~v.a;
    b16 = 16'h5A5A;
    chk({nm, "_busy_after_accept"}, 64'(busy16), 64'd1);
    wait_done16(cyc, bc);
    chk({nm, "_latency"}, 64'(cyc), 64'd4);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'd4);
    chk({nm, "_busy_in_done"}, 64'(busy16), 64'd0);
    chk({nm, "_diff"}, 64'(diff16), 64'(v.diff));
    chk({nm, "_cout"}, 64'(cout16), 64'(v.cout));
    chk({nm, "_zero"}, 64'(zero16), 64'(v.zero));
    chk({nm, "_ovf"}, 64'(ovf16), 64'(exp_ovf));
    tick();
    chk({nm, "_done_one_cycle"}, 64'(done16), 64'd0);
    chk({nm, "_diff_hold"}, 64'(diff16), 64'(v.diff));
    chk({nm, "_cout_hold"}, 64'(cout16), 64'(v.cout));
  endtask

  vec_t vecs[8];

  initial begin
    int cyc, bc, ndone;
    logic exp_ovf;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 16'h9999, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 16'h1E1F, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    start16 = 1'b0; start4 = 1'b0;
    a16 = 16'h0; b16 = 16'h0; a4 = 4'h0; b4 = 4'h0;
    tick();
    tick();
    chk("rst_busy", 64'(busy16), 64'd0);
    chk("rst_done", 64'(done16), 64'd0);
    chk("rst_diff", 64'(diff16), 64'd0);
    chk("rst_cout", 64'(cout16), 64'd0);
    chk("rst_zero", 64'(zero16), 64'd0);
    chk("rst_ovf", 64'(ovf16), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start re-pulsed in the second CALC cycle must be ignored.
    start_op16(16'h0005, 16'h0003);
    tick();
    a16 = 16'h00FF; b16 = 16'h0001; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("ignore_busy", 64'(busy16), 64'd1);
    wait_done16(cyc, bc);
    chk("ignore_latency", 64'(2 + cyc), 64'd4);
    chk("ignore_diff", 64'(diff16), 64'h0002);
    chk("ignore_cout", 64'(cout16), 64'd1);
    // Start presented during the done cycle is accepted immediately.
    start_op16(16'h0100, 16'h0001);
    chk("done_accept_busy", 64'(busy16), 64'd1);
    chk("done_accept_done", 64'(done16), 64'd0);
    wait_done16(cyc, bc);
    chk("done_accept_latency", 64'(cyc), 64'd4);
    chk("done_accept_diff", 64'(diff16), 64'h00FF);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done16) ndone++;
    end
    chk("done_accept_single_pulse", 64'(ndone), 64'd0);
    chk("idle_busy", 64'(busy16), 64'd0);

    // Reset in the second CALC cycle aborts without a done pulse.
    start_op16(16'h1234, 16'h0001);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy16), 64'd0);
    chk("abort_done", 64'(done16), 64'd0);
    chk("abort_diff", 64'(diff16), 64'd0);
    chk("abort_cout", 64'(cout16), 64'd0);
    chk("abort_zero", 64'(zero16), 64'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done16) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    start_op16(16'h0010, 16'h0001);
    wait_done16(cyc, bc);
    chk("after_abort_latency", 64'(cyc), 64'd4);
    chk("after_abort_diff", 64'(diff16), 64'h000F);

    // WIDTH=4: a single CALC cycle.
    a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("w4_busy", 64'(busy4), 64'd1);
    chk("w4_done_early", 64'(done4), 64'd0);
    tick();
    chk("w4_done", 64'(done4), 64'd1);
    chk("w4_diff", 64'(diff4), 64'hE);
    chk("w4_cout", 64'(cout4), 64'd0);
    chk("w4_zero", 64'(zero4), 64'd0);
    // Signed overflow at the narrow width: 8 - 1 = 7.
    a4 = 4'h8; b4 = 4'h1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
`ifdef RESTADOR_SIGNED_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    chk("w4b_done", 64'(done4), 64'd1);
    chk("w4b_diff", 64'(diff4), 64'h7);
    chk("w4b_cout", 64'(cout4), 64'd1);
    chk("w4b_ovf", 64'(ovf4), 64'(exp_ovf));
    tick();
    chk("w4b_done_clear", 64'(done4), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
